// File: rtl/challenge_sequencer.sv
// challenge_sequencer
//   Holds DEPTH 60-bit challenge descriptors in a writable array and steps
//   through ROUNDS of them per game. Each challenge is presented as
//   registered, pre-decoded fields behind a valid/next handshake.
//
//   Descriptor layout: [59:58] opcode, [57:54] leds, [53:52] pos_inicial,
//   [51:40] lim_inf, [39:28] lim_sup, [27:0] expected.
//
//   Optional feature macro: CHALLENGE_SHUFFLE_EN
//     defined   -> each game starts at (free-running LFSR mod DEPTH)
//     undefined -> each game starts at entry 0
//
// Ports
//   clock        in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   start        in   pulse: begin a game (accepted in IDLE/DONE)
//   next         in   pulse: current challenge consumed (PRESENT only)
//   abort        in   pulse: return to IDLE (wins over start/next)
//   prog_we      in   descriptor write enable (accepted in IDLE/DONE)
//   prog_addr    in   descriptor write address
//   prog_data    in   descriptor write data
//   valid        out  fields hold a current challenge
//   done         out  all ROUNDS challenges consumed
//   prog_err     out  pulse: a write was rejected in the previous cycle
//   round        out  0-based index of the current challenge
//   addr_cur     out  array address of the current challenge
//   opcode       out  00 button, 01 button+servo, 10 servo, 11 sensor
//   leds         out  LED select
//   pos_inicial  out  servo start position
//   lim_inf      out  lower limit, 3 BCD digits
//   lim_sup      out  upper limit, 3 BCD digits
//   expected     out  four 7-bit ASCII chars, 0 for sensor challenges
`timescale 1ns/1ps

module challenge_sequencer #(
  parameter int    DEPTH     = 8,
  parameter int    ADDR_W    = 3,
  parameter int    ROUNDS    = 8,
  parameter int    RND_W     = 4,
  parameter string INIT_FILE = ""
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              next,
  input  logic              abort,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [59:0]       prog_data,
  output logic              valid,
  output logic              done,
  output logic              prog_err,
  output logic [RND_W-1:0]  round,
  output logic [ADDR_W-1:0] addr_cur,
  output logic [1:0]        opcode,
  output logic [3:0]        leds,
  output logic [1:0]        pos_inicial,
  output logic [11:0]       lim_inf,
  output logic [11:0]       lim_sup,
  output logic [27:0]       expected
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FETCH   = 2'd1;
  localparam logic [1:0] S_PRESENT = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [1:0]        OP_SENSOR = 2'b11;
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
  localparam logic [RND_W-1:0]  LAST_RND  = RND_W'(ROUNDS - 1);

  logic [59:0]       mem [DEPTH];
  logic [1:0]        state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] offset;
  logic              busy;
  logic              addr_ok;
  logic              wr_ok;

  // Sensor challenges carry no ASCII string; whatever sits in [27:0] is hidden.
  function automatic logic [27:0] mask_expected(input logic [59:0] d);
    return (d[59:58] == OP_SENSOR) ? 28'd0 : d[27:0];
  endfunction

  // Out-of-range addresses (only possible when DEPTH < 2**ADDR_W) are dropped.
  if (DEPTH == (1 << ADDR_W)) begin : g_full
    assign addr_ok = 1'b1;
  end else begin : g_part
    assign addr_ok = (prog_addr <= LAST_IDX);
  end

  assign busy  = (state == S_FETCH) || (state == S_PRESENT);
  assign wr_ok = prog_we && !busy && addr_ok;

  always_ff @(posedge clock) begin
    if (wr_ok) mem[prog_addr] <= prog_data;
  end

`ifdef CHALLENGE_SHUFFLE_EN
  // Fibonacci tap masks (bit n-1 set for tap n) for maximal-length LFSRs.
  function automatic logic [15:0] lfsr_taps(input int w);
    case (w)
      2:       return 16'h0003;
      3:       return 16'h0006;
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h6000;
      16:      return 16'hD008;
      default: return 16'h0001;
    endcase
  endfunction

  localparam logic [15:0]       TAPS     = lfsr_taps(ADDR_W);
  localparam logic [ADDR_W-1:0] TAP_MASK = TAPS[ADDR_W-1:0];

  logic [ADDR_W-1:0] lfsr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) lfsr <= ADDR_W'(1);
    else          lfsr <= (lfsr << 1) | ADDR_W'(^(lfsr & TAP_MASK));
  end

  assign offset = ADDR_W'(32'(lfsr) % DEPTH);
`else
  assign offset = '0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      idx         <= '0;
      round       <= '0;
      valid       <= 1'b0;
      done        <= 1'b0;
      prog_err    <= 1'b0;
      addr_cur    <= '0;
      opcode      <= '0;
      leds        <= '0;
      pos_inicial <= '0;
      lim_inf     <= '0;
      lim_sup     <= '0;
      expected    <= '0;
    end else begin
      prog_err <= prog_we && busy;
      if (abort) begin
        state <= S_IDLE;
        valid <= 1'b0;
        done  <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (start) begin
              state <= S_FETCH;
              idx   <= offset;
              round <= '0;
              done  <= 1'b0;
            end
          end
          // Synchronous array read lands directly in the output field registers.
          S_FETCH: begin
            opcode      <= mem[idx][59:58];
            leds        <= mem[idx][57:54];
            pos_inicial <= mem[idx][53:52];
            lim_inf     <= mem[idx][51:40];
            lim_sup     <= mem[idx][39:28];
            expected    <= mask_expected(mem[idx]);
            addr_cur    <= idx;
            valid       <= 1'b1;
            state       <= S_PRESENT;
          end
          S_PRESENT: begin
            if (next) begin
              valid <= 1'b0;
              if (round == LAST_RND) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                round <= round + 1'b1;
                idx   <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
                state <= S_FETCH;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_challenge_sequencer.sv
// tb_challenge_sequencer
//   Directed bench for challenge_sequencer. Instance a uses ROUNDS=8,
//   instance b uses ROUNDS=10 to exercise address wrap. Stimulus pushes
//   expected presentations into per-instance queues; monitors pop and
//   compare whenever valid or done rises.
`timescale 1ns/1ps

module tb_challenge_sequencer;

  typedef struct {
    bit          is_done;
    logic [2:0]  addr;
    logic [3:0]  rnd;
    logic [59:0] d;
  } exp_t;

  int checks   = 0;
  int failures = 0;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n, start, next, abort, prog_we, prog_we_b, start_b, next_b;
  logic [2:0]  prog_addr;
  logic [59:0] prog_data;

  logic        valid, done, prog_err;
  logic [3:0]  round;
  logic [2:0]  addr_cur;
  logic [1:0]  opcode, pos_inicial;
  logic [3:0]  leds;
  logic [11:0] lim_inf, lim_sup;
  logic [27:0] expected;

  logic        valid_b, done_b, prog_err_b;
  logic [3:0]  round_b;
  logic [2:0]  addr_cur_b;
  logic [1:0]  opcode_b, pos_inicial_b;
  logic [3:0]  leds_b;
  logic [11:0] lim_inf_b, lim_sup_b;
  logic [27:0] expected_b;

  challenge_sequencer #(.DEPTH(8), .ADDR_W(3), .ROUNDS(8), .RND_W(4)) u_dut (
    .clock(clock), .reset_n(reset_n), .start(start), .next(next), .abort(abort),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .valid(valid), .done(done), .prog_err(prog_err), .round(round),
    .addr_cur(addr_cur), .opcode(opcode), .leds(leds), .pos_inicial(pos_inicial),
    .lim_inf(lim_inf), .lim_sup(lim_sup), .expected(expected)
  );

  challenge_sequencer #(.DEPTH(8), .ADDR_W(3), .ROUNDS(10), .RND_W(4)) u_dut_b (
    .clock(clock), .reset_n(reset_n), .start(start_b), .next(next_b), .abort(1'b0),
    .prog_we(prog_we_b), .prog_addr(prog_addr), .prog_data(prog_data),
    .valid(valid_b), .done(done_b), .prog_err(prog_err_b), .round(round_b),
    .addr_cur(addr_cur_b), .opcode(opcode_b), .leds(leds_b), .pos_inicial(pos_inicial_b),
    .lim_inf(lim_inf_b), .lim_sup(lim_sup_b), .expected(expected_b)
  );

  logic [59:0] tab [8];
  exp_t qa[$];
  exp_t qb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  task automatic check_ch(input string tag, input exp_t e, input logic [2:0] a,
                          input logic [3:0] r, input logic [1:0] op, input logic [3:0] l,
                          input logic [1:0] p, input logic [11:0] li, input logic [11:0] ls,
                          input logic [27:0] ex);
    logic [27:0] ex_req;
    if (e.is_done) begin
      fail_now({tag, ".order_valid_before_done"});
    end else begin
      ex_req = (e.d[59:58] == 2'b11) ? 28'd0 : e.d[27:0];
      chk({tag, ".addr_cur"}, 64'(a), 64'(e.addr));
      chk({tag, ".round"}, 64'(r), 64'(e.rnd));
      chk({tag, ".opcode"}, 64'(op), 64'(e.d[59:58]));
      chk({tag, ".leds"}, 64'(l), 64'(e.d[57:54]));
      chk({tag, ".pos_inicial"}, 64'(p), 64'(e.d[53:52]));
      chk({tag, ".lim_inf"}, 64'(li), 64'(e.d[51:40]));
      chk({tag, ".lim_sup"}, 64'(ls), 64'(e.d[39:28]));
      chk({tag, ".expected"}, 64'(ex), 64'(ex_req));
    end
  endtask

  function automatic exp_t mk(input bit is_done, input int a, input int r, input logic [59:0] d);
    exp_t e;
    e.is_done = is_done;
    e.addr    = 3'(a);
    e.rnd     = 4'(r);
    e.d       = d;
    return e;
  endfunction

  // Monitors: one presentation per rising valid, one completion per rising done.
  bit pv_a = 0, pd_a = 0, pv_b = 0, pd_b = 0;
  always @(negedge clock) begin : mon_a
    exp_t e;
    if (reset_n && valid && !pv_a) begin
      if (qa.size() == 0) fail_now("a.unexpected_valid");
      else begin
        e = qa.pop_front();
        check_ch("a", e, addr_cur, round, opcode, leds, pos_inicial, lim_inf, lim_sup, expected);
      end
    end
    if (reset_n && done && !pd_a) begin
      if (qa.size() == 0) fail_now("a.unexpected_done");
      else begin
        e = qa.pop_front();
        chk("a.done_kind", 64'd1, 64'(e.is_done));
        chk("a.done_valid_low", 64'(valid), 64'd0);
      end
    end
    pv_a = valid;
    pd_a = done;
  end

  always @(negedge clock) begin : mon_b
    exp_t e;
    if (reset_n && valid_b && !pv_b) begin
      if (qb.size() == 0) fail_now("b.unexpected_valid");
      else begin
        e = qb.pop_front();
        check_ch("b", e, addr_cur_b, round_b, opcode_b, leds_b, pos_inicial_b,
                 lim_inf_b, lim_sup_b, expected_b);
      end
    end
    if (reset_n && done_b && !pd_b) begin
      if (qb.size() == 0) fail_now("b.unexpected_done");
      else begin
        e = qb.pop_front();
        chk("b.done_kind", 64'd1, 64'(e.is_done));
        chk("b.done_valid_low", 64'(valid_b), 64'd0);
      end
    end
    pv_b = valid_b;
    pd_b = done_b;
  end

  task automatic wait_valid(input bit on_b, input string tag);
    int n = 0;
    @(negedge clock);
    while (((on_b ? valid_b : valid) == 1'b0) && n < 10) begin
      @(negedge clock);
      n++;
    end
    chk(tag, 64'(on_b ? valid_b : valid), 64'd1);
  endtask

  task automatic pulse_next(input bit on_b);
    @(posedge clock); #1;
    if (on_b) next_b = 1'b1; else next = 1'b1;
    @(posedge clock); #1;
    next_b = 1'b0;
    next   = 1'b0;
  endtask

  task automatic pulse_start(input bit on_b);
    @(posedge clock); #1;
    if (on_b) start_b = 1'b1; else start = 1'b1;
    @(posedge clock); #1;
    start_b = 1'b0;
    start   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [59:0] new0;
    bit stable;

    tab[0] = {2'b00, 4'b0001, 2'b00, 12'h000, 12'h000, 28'h4185_0C4};
    tab[1] = {2'b11, 4'b0000, 2'b00, 12'h010, 12'h025, 28'h123_4567};
    tab[2] = {2'b01, 4'b0011, 2'b10, 12'h123, 12'h456, 28'h89A_BCDE};
    tab[3] = {2'b10, 4'b0100, 2'b01, 12'h050, 12'h150, 28'h000_0000};
    tab[4] = {2'b00, 4'b1000, 2'b11, 12'h999, 12'h000, 28'hFFF_FFFF};
    tab[5] = {2'b01, 4'b1111, 2'b00, 12'h001, 12'h002, 28'h5A5_A5A5};
    tab[6] = {2'b11, 4'b1010, 2'b11, 12'h300, 12'h400, 28'hFFF_FFFF};
    tab[7] = {2'b10, 4'b0101, 2'b10, 12'h777, 12'h888, 28'h0DE_F012};
    new0   = {2'b01, 4'b0110, 2'b01, 12'h246, 12'h135, 28'h765_4321};

    reset_n = 1'b0; start = 0; next = 0; abort = 0; prog_we = 0; prog_we_b = 0;
    start_b = 0; next_b = 0; prog_addr = '0; prog_data = '0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst.valid", 64'(valid), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.prog_err", 64'(prog_err), 64'd0);
    chk("rst.round_addr", 64'({round, addr_cur}), 64'd0);
    chk("rst.fields", 64'({opcode, leds, pos_inicial, lim_inf, lim_sup, expected}), 64'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      prog_we = 1'b1; prog_we_b = 1'b1; prog_addr = 3'(i); prog_data = tab[i];
      @(posedge clock); #1;
    end
    prog_we = 1'b0; prog_we_b = 1'b0;

    // Instance b: ten rounds over eight entries wraps 7 -> 0.
    for (int i = 0; i < 10; i++) qb.push_back(mk(0, i % 8, i, tab[i % 8]));
    qb.push_back(mk(1, 0, 0, '0));
    pulse_start(1);
    for (int i = 0; i < 10; i++) begin
      wait_valid(1, "b.valid_wait");
      pulse_next(1);
    end
    @(negedge clock);
    chk("b.done_after_last", 64'(done_b), 64'd1);
    chk("b.final_round", 64'(round_b), 64'd9);

    // Instance a, game 1: full sweep with timing, hold and rejected write.
    for (int i = 0; i < 8; i++) qa.push_back(mk(0, i, i, tab[i]));
    qa.push_back(mk(1, 0, 0, '0));
    @(posedge clock); #1;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(negedge clock);
    chk("a.fetch_cycle_valid", 64'(valid), 64'd0);
    @(negedge clock);
    chk("a.present_cycle_valid", 64'(valid), 64'd1);

    @(posedge clock); #1;
    prog_we = 1'b1; prog_addr = 3'd2; prog_data = ~tab[2];
    @(posedge clock); #1;
    prog_we = 1'b0;
    @(negedge clock);
    chk("a.prog_err_pulse", 64'(prog_err), 64'd1);
    @(negedge clock);
    chk("a.prog_err_clear", 64'(prog_err), 64'd0);

    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (!valid || addr_cur != 3'd0 || round != 4'd0 || leds != tab[0][57:54] ||
          expected != tab[0][27:0]) stable = 1'b0;
    end
    chk("a.hold_stable", 64'(stable), 64'd1);

    for (int i = 0; i < 8; i++) begin
      pulse_next(0);
      if (i < 7) begin
        wait_valid(0, "a.g1_valid_wait");
        if (i == 0) begin
          chk("a.sensor_expected_zero", 64'(expected), 64'd0);
          chk("a.sensor_lim_inf", 64'(lim_inf), 64'h010);
          chk("a.sensor_lim_sup", 64'(lim_sup), 64'h025);
        end
      end else begin
        @(negedge clock);
        chk("a.done_after_8th", 64'(done), 64'd1);
        chk("a.done_round", 64'(round), 64'd7);
      end
    end

    // Game 2 from DONE: entry 2 still holds the old data; abort beats next.
    for (int i = 0; i < 3; i++) qa.push_back(mk(0, i, i, tab[i]));
    pulse_start(0);
    wait_valid(0, "a.g2_valid_wait");
    for (int i = 0; i < 2; i++) begin
      pulse_next(0);
      wait_valid(0, "a.g2_valid_wait");
    end
    @(posedge clock); #1;
    abort = 1'b1; next = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0; next = 1'b0;
    @(negedge clock);
    chk("a.abort_valid", 64'(valid), 64'd0);
    chk("a.abort_done", 64'(done), 64'd0);
    chk("a.abort_round_kept", 64'(round), 64'd2);
    chk("a.abort_addr_kept", 64'(addr_cur), 64'd2);
    pulse_next(0);
    @(negedge clock);
    chk("a.next_in_idle_ignored", 64'(valid), 64'd0);

    // Reset while in FETCH clears everything without waiting for a clock.
    pulse_start(0);
    reset_n = 1'b0;
    #1;
    chk("a.async_rst_addr", 64'(addr_cur), 64'd0);
    chk("a.async_rst_fields", 64'({opcode, leds, pos_inicial, lim_inf, lim_sup, expected}), 64'd0);
    chk("a.async_rst_ctrl", 64'({valid, done, prog_err, round}), 64'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;

    // Write and start together: FETCH sees the freshly written entry.
    tab[0] = new0;
    qa.push_back(mk(0, 0, 0, new0));
    @(posedge clock); #1;
    prog_we = 1'b1; prog_addr = 3'd0; prog_data = new0; start = 1'b1;
    @(posedge clock); #1;
    prog_we = 1'b0; start = 1'b0;
    wait_valid(0, "a.g3_valid_wait");
    @(posedge clock); #1;
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    @(negedge clock);
    chk("a.g3_abort_valid", 64'(valid), 64'd0);

    repeat (3) @(negedge clock);
    chk("a.queue_drained", 64'(qa.size()), 64'd0);
    chk("b.queue_drained", 64'(qb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
